add_approx_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 8-bit approximate adders in the library.
- Lower-part-OR approximate adder of configurable width and approximation depth, with a per-transaction exact/approximate mode select.
- Valid/ready streaming interface with a 2-stage pipeline that accepts backpressure.
- Built-in error monitor: for each result, reports the error against the exact sum and keeps running statistics. Used on accelerator datapaths and in characterisation benches.

---
 rtl/add_approx_pipe.sv | 191 +++++++++++++++++++
 tb/tb_add_approx_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_approx_pipe.sv
// Lower-part-OR approximate adder with a 2-stage valid/ready pipeline and a
// built-in error monitor that tracks count, error count and worst-case error.
module add_approx_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_err,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_cnt,
    output logic [CNT_W-1:0] stat_err_cnt,
    output logic [WIDTH:0]   stat_max_err
);

    localparam int unsigned K  = APPROX_BITS;
    localparam int unsigned LW = (K == 0) ? 1 : K;
    localparam int unsigned HW = WIDTH - K;
    localparam int unsigned SW = WIDTH + 1;

    // Operand split; with no approximate bits the low slice is a constant zero.
    logic [LW-1:0] a_lo, b_lo;
    logic [HW-1:0] a_hi, b_hi;

    generate
        if (K > 0) begin : g_split
            assign a_lo = in_a[K-1:0];
            assign b_lo = in_b[K-1:0];
            assign a_hi = in_a[WIDTH-1:K];
            assign b_hi = in_b[WIDTH-1:K];
        end else begin : g_nosplit
            assign a_lo = '0;
            assign b_lo = '0;
            assign a_hi = in_a;
            assign b_hi = in_b;
        end
    endgenerate

    logic [LW:0] lo_add;
    logic        approx_c;

    assign lo_add   = {1'b0, a_lo} + {1'b0, b_lo};
    assign approx_c = a_lo[LW-1] & b_lo[LW-1];

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load, out_hs;

    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = s1_load;
    assign out_hs   = s2_valid_q & out_ready;

    // Stage 1
    logic [LW-1:0] s1_lo_q, s1_lo_d;
    logic [LW-1:0] s1_ex_lo_q, s1_ex_lo_d;
    logic          s1_c_q, s1_c_d;
    logic          s1_ex_c_q, s1_ex_c_d;
    logic [HW-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [HW-1:0] s1_b_hi_q, s1_b_hi_d;
    logic          s1_mode_q, s1_mode_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_ex_lo_d = s1_ex_lo_q;
        s1_c_d     = s1_c_q;
        s1_ex_c_d  = s1_ex_c_q;
        s1_a_hi_d  = s1_a_hi_q;
        s1_b_hi_d  = s1_b_hi_q;
        s1_mode_d  = s1_mode_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ex_lo_d = lo_add[LW-1:0];
                s1_ex_c_d  = lo_add[LW];
                s1_lo_d    = in_mode ? (a_lo | b_lo) : lo_add[LW-1:0];
                s1_c_d     = in_mode ? approx_c : lo_add[LW];
                s1_a_hi_d  = a_hi;
                s1_b_hi_d  = b_hi;
                s1_mode_d  = in_mode;
            end
        end
    end

    // Stage 2 datapath
    logic [HW:0]    hi_sum, ex_hi_sum;
    logic [SW-1:0]  res_sum, ex_sum, res_err;
    logic [WIDTH:0] out_sum_q, out_sum_d;
    logic [WIDTH:0] out_err_q, out_err_d;

    always_comb begin
        hi_sum    = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q} + {{HW{1'b0}}, s1_c_q};
        ex_hi_sum = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q} + {{HW{1'b0}}, s1_ex_c_q};
        res_sum   = (SW'(hi_sum) << K) | SW'(s1_lo_q);
        ex_sum    = (SW'(ex_hi_sum) << K) | SW'(s1_ex_lo_q);
        // Approximate result can land on either side of the exact sum.
        res_err   = (ex_sum >= res_sum) ? (ex_sum - res_sum) : (res_sum - ex_sum);
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_sum_d  = out_sum_q;
        out_err_d  = out_err_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sum_d = res_sum;
                out_err_d = res_err;
            end
        end
    end

    // Statistics
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH:0]   max_err_q, max_err_d;

    always_comb begin
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        max_err_d = max_err_q;
        if (stat_clr) begin
            cnt_d     = '0;
            err_cnt_d = '0;
            max_err_d = '0;
        end else if (out_hs) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if ((out_err_q != '0) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (out_err_q > max_err_q) begin
                max_err_d = out_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_ex_lo_q <= '0;
            s1_c_q     <= 1'b0;
            s1_ex_c_q  <= 1'b0;
            s1_a_hi_q  <= '0;
            s1_b_hi_q  <= '0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            out_sum_q  <= '0;
            out_err_q  <= '0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            max_err_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_ex_lo_q <= s1_ex_lo_d;
            s1_c_q     <= s1_c_d;
            s1_ex_c_q  <= s1_ex_c_d;
            s1_a_hi_q  <= s1_a_hi_d;
            s1_b_hi_q  <= s1_b_hi_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            out_sum_q  <= out_sum_d;
            out_err_q  <= out_err_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            max_err_q  <= max_err_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sum      = out_sum_q;
    assign out_err      = out_err_q;
    assign stat_cnt     = cnt_q;
    assign stat_err_cnt = err_cnt_q;
    assign stat_max_err = max_err_q;

endmodule

// File: tb/tb_add_approx_pipe.sv
// Bench for add_approx_pipe: three instances (k=2, k=0, k=2 with 4-bit counters)
// share one input stream; directed table, corner sequences and a random run.
module tb_add_approx_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_mode, out_ready, stat_clr;
    logic [7:0] in_a, in_b;

    logic        rdy_m, vld_m, rdy_x, vld_x, rdy_s, vld_s;
    logic [8:0]  sum_m, err_m, max_m, sum_x, err_x, max_x, sum_s, err_s, max_s;
    logic [15:0] cnt_m, ecnt_m, cnt_x, ecnt_x;
    logic [3:0]  cnt_s, ecnt_s;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    add_approx_pipe #(.WIDTH(8), .APPROX_BITS(2), .CNT_W(16)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m), .in_a(in_a),
        .in_b(in_b), .in_mode(in_mode), .out_valid(vld_m), .out_ready(out_ready),
        .out_sum(sum_m), .out_err(err_m), .stat_clr(stat_clr), .stat_cnt(cnt_m),
        .stat_err_cnt(ecnt_m), .stat_max_err(max_m)
    );

    add_approx_pipe #(.WIDTH(8), .APPROX_BITS(0), .CNT_W(16)) u_exact (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_x), .in_a(in_a),
        .in_b(in_b), .in_mode(in_mode), .out_valid(vld_x), .out_ready(out_ready),
        .out_sum(sum_x), .out_err(err_x), .stat_clr(stat_clr), .stat_cnt(cnt_x),
        .stat_err_cnt(ecnt_x), .stat_max_err(max_x)
    );

    add_approx_pipe #(.WIDTH(8), .APPROX_BITS(2), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_a(in_a),
        .in_b(in_b), .in_mode(in_mode), .out_valid(vld_s), .out_ready(out_ready),
        .out_sum(sum_s), .out_err(err_s), .stat_clr(stat_clr), .stat_cnt(cnt_s),
        .stat_err_cnt(ecnt_s), .stat_max_err(max_s)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic [8:0] sum;
        logic [8:0] err;
        logic [8:0] sum_x;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
    } op_t;

    typedef struct {
        logic [8:0] sum;
        logic [8:0] err;
        logic [8:0] ex;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: approximate sum from the arithmetic definition.
    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic m, input int k);
        int unsigned ai, bi, p, lo, c, hi;
        ai = 32'(a);
        bi = 32'(b);
        if (!m || k == 0) return 9'(ai + bi);
        p  = 32'd1 << k;
        lo = (ai | bi) % p;
        c  = ((ai >> (k - 1)) & (bi >> (k - 1))) & 32'd1;
        hi = (ai >> k) + (bi >> k) + c;
        return 9'(hi * p + lo);
    endfunction

    function automatic logic [8:0] ref_err(input logic [7:0] a, input logic [7:0] b,
                                           input logic m, input int k);
        int s, e;
        s = int'(ref_sum(a, b, m, k));
        e = int'(a) + int'(b);
        return 9'((s > e) ? s - e : e - s);
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
        bit ok;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy_m) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        out_ready = 1'b1;
        send(v.a, v.b, v.mode);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early_valid", 32'(vld_m), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(vld_m), 32'd1);
        chk("vec_sum", 32'(sum_m), 32'(v.sum));
        chk("vec_err", 32'(err_m), 32'(v.err));
        chk("vec_sum_exactinst", 32'(sum_x), 32'(v.sum_x));
        chk("vec_err_exactinst", 32'(err_x), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        op_t  bp[3];
        exp_t q[$];
        exp_t e;
        int   idx, acc, got, m_cnt, m_ecnt, m_max;
        logic [8:0] held;
        bit   hs_in, hs_out;

        tbl[0] = '{8'h02, 8'h02, 1'b1, 9'h006, 9'd2, 9'h004};
        tbl[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'd1, 9'h1FE};
        tbl[2] = '{8'h03, 8'h01, 1'b1, 9'h003, 9'd1, 9'h004};
        tbl[3] = '{8'hFF, 8'h01, 1'b0, 9'h100, 9'd0, 9'h100};
        tbl[4] = '{8'h0F, 8'h01, 1'b0, 9'h010, 9'd0, 9'h010};
        tbl[5] = '{8'h0F, 8'h01, 1'b1, 9'h00F, 9'd1, 9'h010};
        tbl[6] = '{8'h80, 8'h80, 1'b1, 9'h100, 9'd0, 9'h100};
        bp[0]  = '{8'h12, 8'h34, 1'b1};
        bp[1]  = '{8'hFF, 8'hFF, 1'b1};
        bp[2]  = '{8'h03, 8'h01, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
        stat_clr = 1'b0; in_a = '0; in_b = '0;
        #3;
        chk("rst_out_valid", 32'(vld_m), 32'd0);
        chk("rst_in_ready", 32'(rdy_m), 32'd1);
        chk("rst_out_sum", 32'(sum_m), 32'd0);
        chk("rst_stat_cnt", 32'(cnt_m), 32'd0);
        #19 rst_n = 1'b1;

        // Directed table with a statistics checkpoint after the first two.
        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i]);
            if (i == 1) begin
                @(negedge clk);
                chk("stat_cnt_2", 32'(cnt_m), 32'd2);
                chk("stat_err_cnt_2", 32'(ecnt_m), 32'd2);
                chk("stat_max_err_2", 32'(max_m), 32'd2);
                chk("stat_err_cnt_exactinst", 32'(ecnt_x), 32'd0);
            end
        end
        @(negedge clk);
        chk("stat_cnt_7", 32'(cnt_m), 32'd7);
        chk("stat_err_cnt_7", 32'(ecnt_m), 32'd4);
        chk("stat_max_err_7", 32'(max_m), 32'd2);
        chk("stat_cnt_small_7", 32'(cnt_s), 32'd7);

        // stat_clr coinciding with a handshake wins.
        send(8'h03, 8'h01, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(negedge clk);
        chk("clr_hs_valid", 32'(vld_m), 32'd1);
        @(posedge clk); #1;
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_stat_cnt", 32'(cnt_m), 32'd0);
        chk("clr_stat_err_cnt", 32'(ecnt_m), 32'd0);
        chk("clr_stat_max_err", 32'(max_m), 32'd0);

        // Backpressure: 5 stalled cycles with 3 back-to-back inputs.
        idx = 0; acc = 0; got = 0; held = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = bp[0].a; in_b = bp[0].b; in_mode = bp[0].m;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            hs_in  = in_valid && rdy_m;
            hs_out = vld_m && out_ready;
            if (cyc == 2) begin
                held = sum_m;
                chk("bp_first_sum", 32'(held), 32'(ref_sum(bp[0].a, bp[0].b, 1'b1, 2)));
            end
            if (cyc == 4) begin
                chk("bp_in_ready", 32'(rdy_m), 32'd0);
                chk("bp_accepted", 32'(acc), 32'd2);
                chk("bp_hold_valid", 32'(vld_m), 32'd1);
                chk("bp_hold_sum", 32'(sum_m), 32'(held));
            end
            if (hs_in) acc++;
            if (hs_out) begin
                chk("bp_order_sum", 32'(sum_m),
                    32'(ref_sum(bp[got].a, bp[got].b, bp[got].m, 2)));
                got++;
            end
            @(posedge clk); #1;
            if (hs_in) begin
                idx++;
                if (idx < 3) begin
                    in_a = bp[idx].a; in_b = bp[idx].b; in_mode = bp[idx].m;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (cyc == 4) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(got), 32'd3);

        // Random stream against the reference model and a statistics model.
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        m_cnt = 0; m_ecnt = 0; m_max = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            hs_in  = in_valid && rdy_m;
            hs_out = vld_m && out_ready;
            if (hs_in) begin
                e.sum = ref_sum(in_a, in_b, in_mode, 2);
                e.err = ref_err(in_a, in_b, in_mode, 2);
                e.ex  = 9'(int'(in_a) + int'(in_b));
                q.push_back(e);
            end
            if (hs_out) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_sum", 32'(sum_m), 32'(e.sum));
                    chk("rnd_err", 32'(err_m), 32'(e.err));
                    chk("rnd_sum_exactinst", 32'(sum_x), 32'(e.ex));
                    m_cnt++;
                    if (e.err != 0) m_ecnt++;
                    if (int'(e.err) > m_max) m_max = int'(e.err);
                end
            end
            @(posedge clk); #1;
            if (cyc < 400) begin
                if (!in_valid || hs_in) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_a     = 8'($urandom);
                    in_b     = 8'($urandom);
                    in_mode  = 1'($urandom_range(0, 1));
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk("rnd_stat_cnt", 32'(cnt_m), 32'(m_cnt));
        chk("rnd_stat_err_cnt", 32'(ecnt_m), 32'(m_ecnt));
        chk("rnd_stat_max_err", 32'(max_m), 32'(m_max));
        chk("rnd_small_cnt_sat", 32'(cnt_s), 32'((m_cnt > 15) ? 15 : m_cnt));
        chk("rnd_small_err_cnt_sat", 32'(ecnt_s), 32'((m_ecnt > 15) ? 15 : m_ecnt));
        chk("rnd_exactinst_max_err", 32'(max_x), 32'd0);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(8'h21, 8'h43, 1'b1);
        send(8'h05, 8'h07, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_valid", 32'(vld_m), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(vld_m), 32'd0);
        chk("rst_mid_sum", 32'(sum_m), 32'd0);
        chk("rst_mid_err", 32'(err_m), 32'd0);
        chk("rst_mid_cnt", 32'(cnt_m), 32'd0);
        chk("rst_mid_max", 32'(max_m), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_post_valid", 32'(vld_m), 32'd0);
        chk("rst_post_ready", 32'(rdy_m), 32'd1);
        run_vec(tbl[2]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
